// File: rtl/vote_pkg.sv
// vote_pkg: shared types and helpers for the vote capture front end.
//   state_e      : session FSM encoding (IDLE / OPEN / CLOSED)
//   *_DEFAULT    : default parameter values for vote_capture
//   popcount()   : number of set bits in a vector of up to POPCOUNT_MAX_W bits
package vote_pkg;

   localparam int NUM_VOTERS_DEFAULT      = 8;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int POPCOUNT_MAX_W          = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_CLOSED = 2'd2
   } state_e;

   // Callers zero-extend their vector into the fixed-width argument.
   function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
         n += {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/voter_debounce.sv
// voter_debounce: conditions one asynchronous voter button.
//   clk, rst_n : system clock, synchronous active-low reset
//   raw_i      : asynchronous button level, active-high
//   rise_o     : registered one-cycle pulse after the debounced level goes 0->1
// A 2-flop synchroniser feeds a counter that must see DEBOUNCE_CYCLES
// consecutive cycles of disagreement before the debounced level follows.
// DEBOUNCE_CYCLES must be at least 1.
module voter_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic rise_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q, deb_d;
   logic          deb_dly_q, deb_dly_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d   = raw_i;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      cnt_d     = '0;
      // Any agreeing cycle restarts the count; the level flips only after
      // DEBOUNCE_CYCLES disagreeing cycles in a row.
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_MAX) begin
            deb_d = ~deb_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      // Edge detect on the settled level, registered so the ballot update
      // lands 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge is sampled.
      deb_dly_d = deb_q;
      rise_d    = deb_q & ~deb_dly_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         rise_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         rise_q    <= rise_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/vote_capture.sv
// vote_capture: voter front end feeding the vote-combining logic.
//   clk, rst_n     : system clock, synchronous active-low reset
//   ena            : design enable; low freezes the FSM and ballot
//   voter_raw      : asynchronous voter buttons, active-high
//   open_i/close_i : session control levels, sampled every cycle
//   ballot_o       : one bit per voter that voted in the current/last session
//   vote_count_o   : popcount of ballot_o, updated on the same edge
//   session_open_o : high while the session is OPEN
//   result_valid_o : one-cycle pulse on the first cycle in CLOSED
// All outputs come straight from flops.
module vote_capture
   import vote_pkg::*;
#(
   parameter int NUM_VOTERS      = NUM_VOTERS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(NUM_VOTERS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [NUM_VOTERS-1:0] voter_raw,
   input  logic                  open_i,
   input  logic                  close_i,
   output logic [NUM_VOTERS-1:0] ballot_o,
   output logic [CNT_W-1:0]      vote_count_o,
   output logic                  session_open_o,
   output logic                  result_valid_o
);

   logic [NUM_VOTERS-1:0] deb_rise;

   // Conditioning runs regardless of ena so the debounced levels stay current.
   for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_voter
      voter_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .raw_i (voter_raw[gi]),
         .rise_o(deb_rise[gi])
      );
   end

   state_e                state_q, state_d;
   logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  open_q, open_d;
   logic                  valid_q, valid_d;
   logic [POPCOUNT_MAX_W-1:0] pc_in;

   always_comb begin
      state_d  = state_q;
      ballot_d = ballot_q;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               if (open_i) begin
                  state_d  = ST_OPEN;
                  ballot_d = '0;
               end
            end
            ST_OPEN: begin
               // OR-in makes repeat presses harmless, and a press on the
               // closing edge still counts.
               ballot_d = ballot_q | deb_rise;
               // close wins over a simultaneous open_i; a full ballot closes
               // on the edge after it fills.
               if (close_i || (&ballot_q)) begin
                  state_d = ST_CLOSED;
               end
            end
            ST_CLOSED: begin
               if (open_i) begin
                  state_d  = ST_OPEN;
                  ballot_d = '0;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               ballot_d = '0;
            end
         endcase
      end

      pc_in                   = '0;
      pc_in[NUM_VOTERS-1:0]   = ballot_d;
      count_d                 = CNT_W'(popcount(pc_in));
      open_d                  = (state_d == ST_OPEN);
      valid_d                 = (state_d == ST_CLOSED) && (state_q != ST_CLOSED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ballot_q <= '0;
         count_q  <= '0;
         open_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ballot_q <= ballot_d;
         count_q  <= count_d;
         open_q   <= open_d;
         valid_q  <= valid_d;
      end
   end

   assign ballot_o       = ballot_q;
   assign vote_count_o   = count_q;
   assign session_open_o = open_q;
   assign result_valid_o = valid_q;

endmodule

// File: tb/tb_vote_capture.sv
module tb_vote_capture;

   logic       clk = 1'b0;
   logic       rst_n, ena, open_i, close_i;
   logic [7:0] voter_raw;
   logic [7:0] ballot_o;
   logic [3:0] vote_count_o;
   logic       session_open_o, result_valid_o;

   always #5 clk = ~clk;

   vote_capture #(.NUM_VOTERS(8), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .voter_raw     (voter_raw),
      .open_i        (open_i),
      .close_i       (close_i),
      .ballot_o      (ballot_o),
      .vote_count_o  (vote_count_o),
      .session_open_o(session_open_o),
      .result_valid_o(result_valid_o)
   );

   typedef struct packed {
      logic [7:0] ballot;
      logic [3:0] cnt;
   } res_t;

   typedef struct {
      logic [7:0] press;
      logic       do_close;   // 0: session is expected to auto-close
      logic [7:0] exp_ballot;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vecs[5];
   res_t exp_q[$];
   res_t obs_q[$];
   int   tests = 0;
   int   fails = 0;
   int   pulse_cnt = 0;

   // Monitor: every result pulse captures what the downstream stage would see.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && result_valid_o === 1'b1) begin
         obs_q.push_back({ballot_o, vote_count_o});
         pulse_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pulse_open();
      open_i = 1'b1;
      step(1);
      open_i = 1'b0;
   endtask

   task automatic pulse_close();
      close_i = 1'b1;
      step(1);
      close_i = 1'b0;
   endtask

   task automatic press(input logic [7:0] m);
      voter_raw = m;
      step(12);
      voter_raw = 8'h00;
      step(10);
   endtask

   task automatic get_result(input string nm);
      res_t e, o;
      int   t;
      t = 0;
      while (obs_q.size() == 0 && t < 40) begin
         step(1);
         t++;
      end
      if (obs_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no result pulse expected one", nm);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s_unexpected: got a result pulse expected none", nm);
         void'(obs_q.pop_front());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({nm, "_ballot"}, 32'(o.ballot), 32'(e.ballot));
         chk({nm, "_count"},  32'(o.cnt),    32'(e.cnt));
      end
   endtask

   initial begin
      int p0;

      vecs[0] = '{8'h08, 1'b1, 8'h08, 4'd1};
      vecs[1] = '{8'h81, 1'b1, 8'h81, 4'd2};
      vecs[2] = '{8'hFF, 1'b0, 8'hFF, 4'd8};
      vecs[3] = '{8'h24, 1'b1, 8'h24, 4'd2};
      vecs[4] = '{8'h00, 1'b1, 8'h00, 4'd0};

      // Reset with every button held.
      rst_n = 1'b0; ena = 1'b1; open_i = 1'b0; close_i = 1'b0; voter_raw = 8'hFF;
      step(2);
      chk("rst_ballot", 32'(ballot_o), 32'h00);
      chk("rst_count",  32'(vote_count_o), 32'h0);
      chk("rst_open",   32'(session_open_o), 32'h0);
      chk("rst_valid",  32'(result_valid_o), 32'h0);
      rst_n = 1'b1; voter_raw = 8'h00;
      step(12);
      chk("idle_open", 32'(session_open_o), 32'h0);
      pulse_close();
      step(2);
      chk("idle_close_ignored", 32'(session_open_o), 32'h0);
      chk("idle_no_pulse", 32'(pulse_cnt), 32'h0);

      // Exact latency: raw set just before edge E0, ballot updates at E7.
      pulse_open();
      chk("open_after_pulse", 32'(session_open_o), 32'h1);
      voter_raw = 8'h08;
      step(7);
      chk("latency_early", 32'(ballot_o), 32'h00);
      step(1);
      chk("latency_ballot", 32'(ballot_o), 32'h08);
      chk("latency_count",  32'(vote_count_o), 32'h1);

      // 3-cycle glitch on voter 5.
      voter_raw = 8'h28;
      step(3);
      voter_raw = 8'h08;
      step(10);
      chk("glitch_ballot", 32'(ballot_o), 32'h08);

      // Voter 2 presses, releases, presses again.
      voter_raw = 8'h0C; step(10);
      voter_raw = 8'h08; step(10);
      voter_raw = 8'h0C; step(10);
      voter_raw = 8'h00; step(10);
      chk("double_ballot", 32'(ballot_o), 32'h0C);
      chk("double_count",  32'(vote_count_o), 32'h2);
      exp_q.push_back({8'h0C, 4'd2});
      pulse_close();
      get_result("double_close");

      // Table: one session per vector.
      for (int v = 0; v < 5; v++) begin
         p0 = pulse_cnt;
         step(2);
         pulse_open();
         chk($sformatf("v%0d_open_clear", v), 32'(ballot_o), 32'h00);
         exp_q.push_back({vecs[v].exp_ballot, vecs[v].exp_cnt});
         press(vecs[v].press);
         if (vecs[v].do_close) begin
            chk($sformatf("v%0d_ballot", v), 32'(ballot_o), 32'(vecs[v].exp_ballot));
            chk($sformatf("v%0d_count", v),  32'(vote_count_o), 32'(vecs[v].exp_cnt));
            pulse_close();
         end
         get_result($sformatf("v%0d_result", v));
         step(3);
         chk($sformatf("v%0d_closed", v), 32'(session_open_o), 32'h0);
         chk($sformatf("v%0d_pulses", v), 32'(pulse_cnt - p0), 32'h1);
         press(8'h10);
         chk($sformatf("v%0d_hold", v), 32'(ballot_o), 32'(vecs[v].exp_ballot));
      end

      // open_i and close_i together while OPEN: close wins.
      pulse_open();
      press(8'h02);
      exp_q.push_back({8'h02, 4'd1});
      open_i = 1'b1; close_i = 1'b1;
      step(1);
      open_i = 1'b0; close_i = 1'b0;
      get_result("simul");
      chk("simul_closed", 32'(session_open_o), 32'h0);
      p0 = pulse_cnt;
      pulse_close();
      step(3);
      chk("closed_close_ignored", 32'(pulse_cnt - p0), 32'h0);

      // Press while frozen is dropped.
      pulse_open();
      ena = 1'b0;
      voter_raw = 8'h02;
      step(15);
      ena = 1'b1;
      step(10);
      chk("freeze_held", 32'(ballot_o), 32'h00);
      voter_raw = 8'h00;
      step(10);
      chk("freeze_after", 32'(ballot_o), 32'h00);
      exp_q.push_back({8'h00, 4'd0});
      pulse_close();
      get_result("freeze_close");

      // Reset mid-session: votes discarded, no result pulse.
      pulse_open();
      press(8'h01);
      chk("midrst_pre", 32'(ballot_o), 32'h01);
      p0 = pulse_cnt;
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("midrst_ballot", 32'(ballot_o), 32'h00);
      chk("midrst_count",  32'(vote_count_o), 32'h0);
      chk("midrst_open",   32'(session_open_o), 32'h0);
      chk("midrst_pulse",  32'(pulse_cnt - p0), 32'h0);

      chk("sb_exp_empty", 32'(exp_q.size()), 32'h0);
      chk("sb_obs_empty", 32'(obs_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
